mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the instruction-fetch requester and the load/store requester of the RV32I core.
//  - Sits between core fetch/LSU and the memory macro.
//  - One transaction outstanding at a time; each response is routed back to its owner.
//  - Fixed priority by default: data wins over fetch. Optional round-robin.

---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and widths for the fetch/LSU memory port arbiter
package mem_port_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding arbiter sharing a memory between fetch and load/store
// Round-robin priority is enabled by defining ARB_ROUND_ROBIN_EN; default is fixed data-over-fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = mem_port_arbiter_pkg::DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [BE_WIDTH-1:0]   d_be_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  err_o
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  arb_owner_t sel, prio;
  logic       store_q, store_d;
  logic       err_q, err_d;
  logic       granted;

  function automatic arb_owner_t pick_owner(input logic if_req, input logic d_req,
                                            input arb_owner_t pri);
    if (d_req && (!if_req || pri == OWN_D)) return OWN_D;
    return OWN_IF;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q remembers the last granted requester; the other one wins the next tie
  arb_owner_t rr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rr_q <= OWN_IF;
    else if (granted) rr_q <= sel;
  end

  assign prio = (rr_q == OWN_D) ? OWN_IF : OWN_D;
`else
  assign prio = OWN_D;
`endif

  assign sel = pick_owner(if_req_i, d_req_i, prio);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      store_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      store_q <= store_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    store_d     = store_q;
    err_d       = err_q;
    granted     = 1'b0;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    if_rdata_o  = '0;
    d_rdata_o   = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;

    // Outputs are forced quiet while reset is held, even with live inputs
    if (rst_n_i) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (mem_rvalid_i) err_d = 1'b1;
          if (if_req_i || d_req_i) begin
            mem_req_o = 1'b1;
            if (sel == OWN_D) begin
              mem_we_o    = d_we_i;
              mem_addr_o  = d_addr_i;
              mem_wdata_o = d_wdata_i;
              mem_be_o    = d_be_i;
              d_gnt_o     = mem_gnt_i;
            end else begin
              mem_addr_o  = if_addr_i;
              mem_be_o    = '1;
              if_gnt_o    = mem_gnt_i;
            end
            if (mem_gnt_i) begin
              granted = 1'b1;
              state_d = ARB_BUSY;
              owner_d = sel;
              store_d = (sel == OWN_D) && d_we_i;
            end
          end
        end
        ARB_BUSY: begin
          if (mem_rvalid_i) begin
            state_d = ARB_IDLE;
            if (owner_q == OWN_D) begin
              d_rvalid_o = 1'b1;
              d_rdata_o  = store_q ? '0 : mem_rdata_i;
            end else begin
              if_rvalid_o = 1'b1;
              if_rdata_o  = mem_rdata_i;
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0;
    d_wdata_i = 0; d_be_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic do_reset();
    tick(); idle_inputs(); rst_n_i = 0;
    tick(); rst_n_i = 1;
  endtask

  initial begin
    logic exp_d;
    idle_inputs();
    rst_n_i = 0;

    // Reset with random inputs: every output quiet
    for (int i = 0; i < 3; i++) begin
      tick();
      if_req_i = 1'($urandom); if_addr_i = $urandom; d_req_i = 1'($urandom);
      d_we_i = 1'($urandom); d_addr_i = $urandom; d_wdata_i = $urandom;
      d_be_i = 4'($urandom); mem_gnt_i = 1'($urandom); mem_rvalid_i = 1'($urandom);
      mem_rdata_i = $urandom;
      settle();
      chk("rst_outputs", {if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o},
          64'd0);
      chk("rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_be_o}, 64'd0);
      chk("rst_misc", {d_rdata_o, mem_wdata_o}, 64'd0);
      chk("rst_err", err_o, 0);
    end
    tick(); idle_inputs(); rst_n_i = 1; settle();
    chk("post_rst_req", mem_req_o, 0);

    // Single fetch with two idle cycles before the response
    tick(); if_req_i = 1; if_addr_i = 32'h10; mem_gnt_i = 1; settle();
    chk("fetch_gnt", if_gnt_o, 1);
    chk("fetch_dgnt", d_gnt_o, 0);
    chk("fetch_mreq", mem_req_o, 1);
    chk("fetch_addr", mem_addr_o, 32'h10);
    chk("fetch_we", mem_we_o, 0);
    chk("fetch_be", mem_be_o, 4'hF);
    tick(); if_req_i = 0; mem_gnt_i = 0; settle();
    chk("busy_mreq", mem_req_o, 0);
    tick(); settle();
    chk("busy_rvalid", if_rvalid_o, 0);
    // Response cycle with a store already pending: no grant allowed here
    tick(); mem_rvalid_i = 1; mem_rdata_i = 32'h00500093;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h100; d_wdata_i = 32'hDEADBEEF; d_be_i = 4'b0011;
    mem_gnt_i = 1; settle();
    chk("fetch_rvalid", if_rvalid_o, 1);
    chk("fetch_rdata", if_rdata_o, 32'h00500093);
    chk("fetch_d_rvalid", d_rvalid_o, 0);
    chk("resp_no_gnt", {mem_req_o, d_gnt_o, if_gnt_o}, 0);

    // Store
    tick(); mem_rvalid_i = 0; mem_rdata_i = 0; settle();
    chk("st_gnt", d_gnt_o, 1);
    chk("st_we", mem_we_o, 1);
    chk("st_addr", mem_addr_o, 32'h100);
    chk("st_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("st_be", mem_be_o, 4'b0011);
    chk("fetch_rvalid_gone", if_rvalid_o, 0);
    tick(); d_req_i = 0; d_we_i = 0; mem_gnt_i = 0; settle();
    chk("st_busy", mem_wdata_o, 0);
    tick(); mem_rvalid_i = 1; mem_rdata_i = 32'h12345678; settle();
    chk("st_ack", d_rvalid_o, 1);
    chk("st_ack_rdata", d_rdata_o, 0);
    chk("st_ack_if", if_rvalid_o, 0);
    tick(); mem_rvalid_i = 0; mem_rdata_i = 0;

    // Memory stall: three refused cycles, accepted on the fourth
    if_req_i = 1; if_addr_i = 32'h44; settle();
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", mem_req_o, 1);
      chk("stall_gnt", if_gnt_o, 0);
      chk("stall_addr", mem_addr_o, 32'h44);
      tick(); settle();
    end
    mem_gnt_i = 1; #0; settle();
    chk("stall_gnt4", if_gnt_o, 1);
    tick(); if_req_i = 0; mem_gnt_i = 0;
    tick(); mem_rvalid_i = 1; mem_rdata_i = 32'h77; settle();
    chk("stall_rdata", if_rdata_o, 32'h77);
    tick(); mem_rvalid_i = 0; mem_rdata_i = 0; settle();
    chk("err_before_spur", err_o, 0);

    // Spurious response in IDLE
    tick(); mem_rvalid_i = 1; mem_rdata_i = 32'hABC; settle();
    chk("spur_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
    tick(); mem_rvalid_i = 0; settle();
    chk("spur_err", err_o, 1);

    // Reset while BUSY; late response afterwards is spurious
    do_reset(); settle();
    chk("rst_clears_err", err_o, 0);
    tick(); if_req_i = 1; if_addr_i = 32'h80; mem_gnt_i = 1; settle();
    chk("pre_rst_gnt", if_gnt_o, 1);
    tick(); if_req_i = 0; mem_gnt_i = 0; rst_n_i = 0; settle();
    chk("mid_rst_req", mem_req_o, 0);
    tick(); rst_n_i = 1; if_req_i = 1; settle();
    chk("after_rst_idle", mem_req_o, 1);
    chk("after_rst_err", err_o, 0);
    tick(); if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55; settle();
    chk("late_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
    tick(); mem_rvalid_i = 0; settle();
    chk("late_err", err_o, 1);

    // Contention: both requesters held for four transactions
    do_reset();
    if_req_i = 1; if_addr_i = 32'h20; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h200;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      mem_gnt_i = 1; mem_rvalid_i = 0; settle();
      chk("cont_dgnt", d_gnt_o, exp_d);
      chk("cont_ifgnt", if_gnt_o, !exp_d);
      chk("cont_addr", mem_addr_o, exp_d ? 32'h200 : 32'h20);
      tick(); mem_gnt_i = 0;
      tick(); mem_rvalid_i = 1; mem_rdata_i = 32'hC0 + k; settle();
      chk("cont_d_rvalid", d_rvalid_o, exp_d);
      chk("cont_if_rvalid", if_rvalid_o, !exp_d);
      chk("cont_rdata", exp_d ? d_rdata_o : if_rdata_o, 32'hC0 + k);
      tick();
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
